// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM access controller: default widths,
// SRAM base address and the legacy-compatible FSM state encoding.
package mem_access_ctrl_pkg;

    localparam int WORD_WIDTH_DEF      = 32;
    localparam int SRAM_DATA_WIDTH_DEF = 16;
    localparam int SRAM_ADDR_WIDTH_DEF = 18;
    localparam int WAIT_CYCLES_DEF     = 5;
    localparam int BASE_ADDR_DEF       = 1024;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Counter preload so that a phase lasts exactly `cycles` clocks.
    function automatic logic [3:0] wait_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// External 16-bit SRAM bus; the controller drives it as master, the memory
// (or its model) responds as slave.
interface mem_access_ctrl_if
    #(
        parameter int SRAM_DATA_WIDTH = mem_access_ctrl_pkg::SRAM_DATA_WIDTH_DEF,
        parameter int SRAM_ADDR_WIDTH = mem_access_ctrl_pkg::SRAM_ADDR_WIDTH_DEF
    );

    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata;
    logic [SRAM_DATA_WIDTH-1:0] sram_rdata;
    logic                       sram_we_n;
    logic                       sram_oe_n;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_we_n,
        output sram_oe_n,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// 4-bit wait-state down-counter with synchronous load/decrement and a zero
// flag; it times each halfword phase of the SRAM controller.
module wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_r;

    // Load has priority so a phase boundary can restart the count on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: splits each 32-bit load/store into two timed
// halfword SRAM transactions, freezing the pipeline until the word completes.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
    #(
        parameter int WORD_WIDTH      = WORD_WIDTH_DEF,
        parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
        parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
        parameter int WAIT_CYCLES     = WAIT_CYCLES_DEF,
        parameter int BASE_ADDR       = BASE_ADDR_DEF
    )
    (
        input  logic                  clk,
        input  logic                  rst,
        input  logic                  mem_read_in,
        input  logic                  mem_write_in,
        input  logic [WORD_WIDTH-1:0] addr_in,
        input  logic [WORD_WIDTH-1:0] wdata_in,
        output logic [WORD_WIDTH-1:0] rdata_out,
        output logic                  ready,
        output logic                  freeze,
        mem_access_ctrl_if.master     bus
    );

    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    logic [1:0]                 state_r;
    logic                       is_write_r;
    logic [SRAM_ADDR_WIDTH-2:0] word_r;
    logic [SRAM_DATA_WIDTH-1:0] wdata_hi_r;
    logic [SRAM_DATA_WIDTH-1:0] rdata_lo_r;
    logic [WORD_WIDTH-1:0]      rdata_r;
    logic                       ready_r;
    logic [SRAM_ADDR_WIDTH-1:0] addr_r;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata_r;
    logic                       we_n_r;
    logic                       oe_n_r;

    logic                       req_s;
    logic                       freeze_s;
    logic                       cnt_load_s;
    logic                       cnt_dec_s;
    logic                       cnt_zero_s;
    logic [WORD_WIDTH-1:0]      addr_off_s;
    logic [SRAM_ADDR_WIDTH-2:0] word_s;

    assign req_s      = mem_read_in | mem_write_in;
    assign addr_off_s = addr_in - WORD_WIDTH'(BASE_ADDR);
    assign word_s     = addr_off_s[2 +: SRAM_ADDR_WIDTH-1];

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero_s)
    );

    // Freeze and wait-counter control decoded from the current state.
    always_comb begin
        freeze_s   = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                freeze_s   = req_s;
                cnt_load_s = req_s;
            end
            ST_LOW: begin
                freeze_s = 1'b1;
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_HIGH: begin
                freeze_s  = 1'b1;
                cnt_dec_s = ~cnt_zero_s;
            end
            default: begin
                freeze_s = 1'b0;
            end
        endcase
    end

    // Held reset must not stall the pipeline even if a request is still presented.
    assign freeze = freeze_s & rst;

    // FSM, SRAM bus registers and load-data assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            is_write_r   <= 1'b0;
            word_r       <= '0;
            wdata_hi_r   <= '0;
            rdata_lo_r   <= '0;
            rdata_r      <= '0;
            ready_r      <= 1'b0;
            addr_r       <= '0;
            sram_wdata_r <= '0;
            we_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (req_s) begin
                        is_write_r   <= mem_write_in;
                        word_r       <= word_s;
                        wdata_hi_r   <= wdata_in[WORD_WIDTH-1 -: SRAM_DATA_WIDTH];
                        addr_r       <= {word_s, 1'b0};
                        sram_wdata_r <= wdata_in[SRAM_DATA_WIDTH-1:0];
                        we_n_r       <= ~mem_write_in;
                        oe_n_r       <= mem_write_in;
                        state_r      <= ST_LOW;
                    end else begin
                        we_n_r <= 1'b1;
                        oe_n_r <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_zero_s) begin
                        if (!is_write_r) begin
                            rdata_lo_r <= bus.sram_rdata;
                        end
                        addr_r       <= {word_r, 1'b1};
                        sram_wdata_r <= wdata_hi_r;
                        state_r      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_zero_s) begin
                        if (!is_write_r) begin
                            rdata_r <= {bus.sram_rdata, rdata_lo_r};
                        end
                        ready_r <= 1'b1;
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The pipeline advances on this edge, so the visible request is stale.
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata_out      = rdata_r;
    assign ready          = ready_r;
    assign bus.sram_addr  = addr_r;
    assign bus.sram_wdata = sram_wdata_r;
    assign bus.sram_we_n  = we_n_r;
    assign bus.sram_oe_n  = oe_n_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle bus/freeze/ready traces of
// each access are compared against hand-derived sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        ready;
    logic        freeze;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] model_mem [0:7];

    logic        obs_freeze [0:12];
    logic        obs_ready  [0:12];
    logic        obs_we     [0:12];
    logic        obs_oe     [0:12];
    logic [17:0] obs_addr   [0:12];
    logic [15:0] obs_wd     [0:12];
    logic [31:0] obs_rd     [0:12];
    int          obs_cyc    [0:12];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl_if #(.SRAM_DATA_WIDTH(16), .SRAM_ADDR_WIDTH(18)) bus ();

    assign bus.sram_rdata = bus.sram_oe_n ? 16'h0000 : model_mem[bus.sram_addr[2:0]];

    mem_access_ctrl #(
        .WORD_WIDTH      (32),
        .SRAM_DATA_WIDTH (16),
        .SRAM_ADDR_WIDTH (18),
        .WAIT_CYCLES     (5),
        .BASE_ADDR       (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .rdata_out    (rdata_out),
        .ready        (ready),
        .freeze       (freeze),
        .bus          (bus)
    );

    task automatic sample(input int i);
        obs_freeze[i] = freeze;
        obs_ready[i]  = ready;
        obs_we[i]     = bus.sram_we_n;
        obs_oe[i]     = bus.sram_oe_n;
        obs_addr[i]   = bus.sram_addr;
        obs_wd[i]     = bus.sram_wdata;
        obs_rd[i]     = rdata_out;
        obs_cyc[i]    = cyc;
    endtask

    // Index 0 = request cycle, 1..5 LOW, 6..10 HIGH, 11 DONE, 12 following cycle.
    task automatic cap_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic nrd, input logic nwr,
                              input logic [31:0] na, input logic [31:0] nd);
        @(negedge clk);
        mem_read_in = rd; mem_write_in = wr; addr_in = a; wdata_in = d;
        #1; sample(0);
        for (int i = 1; i < 12; i++) begin
            @(posedge clk); #1; sample(i);
        end
        @(posedge clk); #1;
        mem_read_in = nrd; mem_write_in = nwr; addr_in = na; wdata_in = nd;
        #1; sample(12);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        addr_in = 32'h0; wdata_in = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if (freeze !== 1'b0 || ready !== 1'b0 || rdata_out !== 32'h0 ||
            bus.sram_addr !== 18'h0 || bus.sram_wdata !== 16'h0 ||
            bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1)
            $display("FAIL reset got fr=%0b rdy=%0b rd=%h a=%h wd=%h we=%0b oe=%0b exp 0 0 0 0 0 1 1",
                     freeze, ready, rdata_out, bus.sram_addr, bus.sram_wdata, bus.sram_we_n, bus.sram_oe_n);
        if (freeze !== 1'b0 || ready !== 1'b0 || rdata_out !== 32'h0 ||
            bus.sram_addr !== 18'h0 || bus.sram_wdata !== 16'h0 ||
            bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) bad++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (freeze !== 1'b0 || ready !== 1'b0 || bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin
                bad++;
                $display("FAIL idle cyc%0d got fr=%0b rdy=%0b we=%0b oe=%0b exp 0 0 1 1",
                         i, freeze, ready, bus.sram_we_n, bus.sram_oe_n);
            end
        end
    endtask

    task automatic test_read(input string nm, input logic [31:0] a, input logic [17:0] hw_lo,
                             input logic [31:0] exp_rd);
        logic lo, hi;
        cap_access(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 13; i++) begin
            lo = (i >= 1 && i <= 5);
            hi = (i >= 6 && i <= 10);
            total++;
            if (obs_freeze[i] !== logic'(i <= 10) || obs_ready[i] !== logic'(i == 11)) begin
                bad++;
                $display("FAIL %s_ctrl cyc%0d got fr=%0b rdy=%0b exp fr=%0b rdy=%0b", nm, i,
                         obs_freeze[i], obs_ready[i], logic'(i <= 10), logic'(i == 11));
            end
            total++;
            if (obs_oe[i] !== !(lo || hi) || obs_we[i] !== 1'b1) begin
                bad++;
                $display("FAIL %s_strobe cyc%0d got oe=%0b we=%0b exp oe=%0b we=1", nm, i,
                         obs_oe[i], obs_we[i], !(lo || hi));
            end
            if (lo || hi) begin
                total++;
                if (obs_addr[i] !== (hi ? hw_lo + 18'd1 : hw_lo)) begin
                    bad++;
                    $display("FAIL %s_addr cyc%0d got=%h exp=%h", nm, i, obs_addr[i],
                             hi ? hw_lo + 18'd1 : hw_lo);
                end
            end
        end
        total++;
        if (obs_rd[11] !== exp_rd) begin
            bad++;
            $display("FAIL %s_rdata got=%h exp=%h", nm, obs_rd[11], exp_rd);
        end
    endtask

    task automatic test_write(input string nm, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [17:0] hw_lo, input logic [31:0] keep_rd);
        logic lo, hi;
        cap_access(rd, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 13; i++) begin
            lo = (i >= 1 && i <= 5);
            hi = (i >= 6 && i <= 10);
            total++;
            if (obs_freeze[i] !== logic'(i <= 10) || obs_ready[i] !== logic'(i == 11)) begin
                bad++;
                $display("FAIL %s_ctrl cyc%0d got fr=%0b rdy=%0b exp fr=%0b rdy=%0b", nm, i,
                         obs_freeze[i], obs_ready[i], logic'(i <= 10), logic'(i == 11));
            end
            total++;
            if (obs_we[i] !== !(lo || hi) || obs_oe[i] !== 1'b1) begin
                bad++;
                $display("FAIL %s_strobe cyc%0d got we=%0b oe=%0b exp we=%0b oe=1", nm, i,
                         obs_we[i], obs_oe[i], !(lo || hi));
            end
            if (lo || hi) begin
                total++;
                if (obs_addr[i] !== (hi ? hw_lo + 18'd1 : hw_lo) ||
                    obs_wd[i] !== (hi ? d[31:16] : d[15:0])) begin
                    bad++;
                    $display("FAIL %s_bus cyc%0d got a=%h wd=%h exp a=%h wd=%h", nm, i, obs_addr[i],
                             obs_wd[i], hi ? hw_lo + 18'd1 : hw_lo, hi ? d[31:16] : d[15:0]);
                end
            end
        end
        total++;
        if (obs_rd[11] !== keep_rd) begin
            bad++;
            $display("FAIL %s_rdata_kept got=%h exp=%h", nm, obs_rd[11], keep_rd);
        end
    endtask

    task automatic test_back_to_back();
        int start_cyc;
        cap_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b1, 32'd1036, 32'h13572468);
        start_cyc = obs_cyc[0];
        total++;
        if (obs_rd[11] !== 32'h0F0E9ABC || obs_addr[1] !== 18'd4) begin
            bad++;
            $display("FAIL b2b_read got rd=%h a=%h exp rd=0f0e9abc a=4", obs_rd[11], obs_addr[1]);
        end
        total++;
        if (obs_freeze[12] !== 1'b1 || obs_oe[12] !== 1'b1 || obs_we[12] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle got fr=%0b oe=%0b we=%0b exp 1 1 1", obs_freeze[12], obs_oe[12], obs_we[12]);
        end
        test_write("b2b_write", 1'b0, 32'd1036, 32'h13572468, 18'd6, 32'h0F0E9ABC);
        total++;
        if (obs_cyc[11] - start_cyc + 1 !== 24) begin
            bad++;
            $display("FAIL b2b_cycles got=%0d exp=24", obs_cyc[11] - start_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read_in = 1'b0; mem_write_in = 1'b1; addr_in = 32'd1024; wdata_in = 32'h55AA33CC;
        repeat (8) @(posedge clk);
        #2; rst = 1'b0; #1;
        total++;
        if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1 || freeze !== 1'b0 || ready !== 1'b0 ||
            bus.sram_addr !== 18'h0 || bus.sram_wdata !== 16'h0 || rdata_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got we=%0b oe=%0b fr=%0b rdy=%0b a=%h wd=%h rd=%h exp 1 1 0 0 0 0 0",
                     bus.sram_we_n, bus.sram_oe_n, freeze, ready, bus.sram_addr, bus.sram_wdata, rdata_out);
        end
        @(negedge clk); mem_write_in = 1'b0;
        @(negedge clk); rst = 1'b1;
        test_read("post_reset_read", 32'd1028, 18'd2, 32'h12345678);
    endtask

    initial begin
        model_mem[0] = 16'h1111; model_mem[1] = 16'h2222;
        model_mem[2] = 16'h5678; model_mem[3] = 16'h1234;
        model_mem[4] = 16'h9ABC; model_mem[5] = 16'h0F0E;
        model_mem[6] = 16'h4444; model_mem[7] = 16'h7777;
        test_reset();
        test_idle();
        test_read("read", 32'd1028, 18'd2, 32'h12345678);
        test_write("write", 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h12345678);
        test_back_to_back();
        test_write("both_strobes", 1'b1, 32'd1024, 32'hCAFEF00D, 18'd0, 32'h0F0E9ABC);
        test_read("wrap_read", 32'd0, 18'h3FE00, 32'h22221111);
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences MEM-stage data accesses for the pipeline onto a 16-bit external SRAM with fixed wait states. It takes the memory command held in the EXE/MEM pipeline register (address, store data, read/write strobes) and splits each 32-bit word access into two halfword transactions. While a transaction is in flight it asserts `freeze`, which holds every pipeline register. It returns the assembled load word with a one-cycle `ready` pulse.

## Interface
- `WORD_WIDTH`, 32: datapath word width; same value as `` `WORD_WIDTH `` in settings.h.
- `SRAM_DATA_WIDTH`, 16: SRAM data bus width; must be WORD_WIDTH/2.
- `SRAM_ADDR_WIDTH`, 18: SRAM halfword address width.
- `WAIT_CYCLES`, 5: cycles each halfword access is held on the bus; legal range 1..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM halfword 0.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low (0 = reset).
- `mem_read_in`, in, 1: load request, from EXE/MEM register.
- `mem_write_in`, in, 1: store request, from EXE/MEM register.
- `addr_in`, in, WORD_WIDTH: byte address (ALU result); must be word aligned.
- `wdata_in`, in, WORD_WIDTH: store data (Rm value).
- `rdata_out`, out, WORD_WIDTH: load data; valid while `ready`=1, then held.
- `ready`, out, 1: one-cycle pulse marking access completion.
- `freeze`, out, 1: hold all pipeline registers this cycle.
- `sram_addr`, out, SRAM_ADDR_WIDTH: SRAM halfword address.
- `sram_wdata`, out, SRAM_DATA_WIDTH: SRAM write data.
- `sram_rdata`, in, SRAM_DATA_WIDTH: SRAM read data.
- `sram_we_n`, out, 1: SRAM write enable, active-low.
- `sram_oe_n`, out, 1: SRAM output enable, active-low.

## Operation
- **States:** IDLE, LOW, HIGH, DONE.
- **Request:** `req = mem_read_in | mem_write_in`.
- **Reset values (asynchronous, rst=0):**
  - State goes to IDLE.
  - `rdata_out`=0, `ready`=0, `sram_addr`=0, `sram_wdata`=0.
  - `sram_we_n`=1, `sram_oe_n`=1.
  - Wait counter=0.
- **Address mapping:**
  - `word = (addr_in - BASE_ADDR) >> 2`, truncated to SRAM_ADDR_WIDTH-1 bits.
  - Low halfword at `{word,1'b0}`; high halfword at `{word,1'b1}`.
  - Subtraction wraps modulo 2^WORD_WIDTH; no range check.
- **IDLE:**
  - `freeze = req`, combinational, in the same cycle.
  - On an edge with req=1, latch operation (write if `mem_write_in`, else read), address and `wdata_in`, then go to LOW.
  - Counter loads WAIT_CYCLES-1.
- **LOW:**
  - Drive the low halfword address.
  - Write: `sram_wdata = wdata[15:0]`, `sram_we_n`=0. Read: `sram_oe_n`=0.
  - Counter decrements each cycle.
  - On the edge where counter==0: a read captures `sram_rdata` into `rdata[15:0]`; go to HIGH and reload the counter.
- **HIGH:**
  - Same as LOW for the high halfword; a read captures into `rdata[31:16]`.
  - Go to DONE when the counter reaches 0.
- **DONE:**
  - `ready`=1, `freeze`=0; SRAM strobes deasserted.
  - Always go to IDLE next; the request still visible in this cycle is not re-issued, because the pipeline advances on this edge.
- **Freeze in LOW/HIGH:** `freeze`=1.
- **Both strobes high:** write takes priority; `rdata_out` unchanged.
- **Write completion:** `rdata_out` unchanged; `ready` still pulses.
- **Inputs during LOW/HIGH:** changes are ignored; values latched in IDLE are used.
- **Reset mid-access:** abort immediately. Strobes return to 1 asynchronously and no partial write is retried.

## Timing
- **Frozen cycles:** 1 + 2·WAIT_CYCLES per access, then one DONE cycle with `ready`=1.
  - With WAIT_CYCLES=5: 11 frozen cycles, `ready` in cycle 12 counting the request cycle as 1.
- **Back-to-back accesses:** a new request is first seen in the IDLE cycle after DONE; minimum 2+2·WAIT_CYCLES cycles per access.
- **Registered outputs:** `sram_*` outputs, `ready` and `rdata_out` are registered.
- **Combinational output:** `freeze` is combinational from state and `req`.
- **Read sampling:** `sram_rdata` is sampled at the end of the last cycle of each halfword phase.

## Structure
- **Shared package / settings.h:** state encoding constants (IDLE/LOW/HIGH/DONE), and WORD_WIDTH and BASE_ADDR defaults.
- **Sub-module `wait_counter`:** 4-bit down-counter with load, decrement and zero flag, instantiated once.
- The FSM and datapath registers remain in the top module.

## Test plan
- **Read:** SRAM model holds hw2=0x5678 and hw3=0x1234; `mem_read_in`=1, addr 1028 → `freeze` high for 11 cycles, `sram_addr` 2 then 3, `ready` pulse with `rdata_out`=0x12345678.
- **Write:** addr 1024, data 0xDEADBEEF → `sram_we_n` low 5 cycles at addr 0 with 0xBEEF, then 5 cycles at addr 1 with 0xDEAD; `ready` pulses; `rdata_out` unchanged.
- **Back-to-back:** read, then write presented in the cycle after DONE → second access starts from IDLE with no re-issue of the first; 24 total cycles including both DONE cycles.
- **Simultaneous strobes:** `mem_read_in`=`mem_write_in`=1 → write sequence only; `rdata_out` unchanged.
- **Reset mid-access:** assert `rst`=0 during HIGH of a write → `sram_we_n`=1 and `freeze`=0 immediately, all outputs at reset values; after release, a new read completes normally.
- **No request:** idle with no request → `freeze`=0, `ready`=0, `sram_oe_n`=`sram_we_n`=1 indefinitely.
